// File: rtl/pulse_seq_if.sv
// Write-only configuration port for pulse_seq: selects a channel compare or the period
// register and carries the value to load into it.
interface pulse_seq_if #(
  parameter int WIDTH  = 26,
  parameter int CHAN_W = 2
);
  // Handshake: cfg_we qualifies cfg_chan/cfg_sel/cfg_data for exactly one cycle. There is
  // no ready; the slave accepts every qualified beat, and the write lands on that rising edge.
  logic              cfg_we;
  logic [CHAN_W-1:0] cfg_chan;
  logic [1:0]        cfg_sel;
  logic [WIDTH-1:0]  cfg_data;

  modport master (output cfg_we, cfg_chan, cfg_sel, cfg_data);
  modport slave  (input  cfg_we, cfg_chan, cfg_sel, cfg_data);
endinterface

// File: rtl/pulse_seq.sv
// Multi-channel timing generator: a free-running counter with a programmable terminal count
// drives per-channel set/clear windows, set-match strobes (PULSE_SEQ_STROBE_EN), wrap and led.
module pulse_seq #(
  parameter int               WIDTH          = 26,
  parameter int               CHANNELS       = 4,
  parameter logic [WIDTH-1:0] PERIOD_DEFAULT = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] SET_DEFAULT    = WIDTH'(572),
  parameter logic [WIDTH-1:0] CLR_DEFAULT    = WIDTH'(999),
  parameter int               LED_BIT        = WIDTH - 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                en,
  pulse_seq_if.slave          cfg,
  output logic                led,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] strobe,
  output logic                wrap
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] SEL_SET    = 2'd0;
  localparam logic [1:0] SEL_CLR    = 2'd1;
  localparam logic [1:0] SEL_PERIOD = 2'd2;

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    period_q, period_d;
  logic [WIDTH-1:0]    set_q [CHANNELS];
  logic [WIDTH-1:0]    set_d [CHANNELS];
  logic [WIDTH-1:0]    clr_q [CHANNELS];
  logic [WIDTH-1:0]    clr_d [CHANNELS];
  logic [CHANNELS-1:0] level_q, level_d;
  logic                wrap_q, wrap_d;

  logic                terminal;
  logic [CHANNELS-1:0] set_hit;
  logic [CHANNELS-1:0] clr_hit;

  // >= rather than == so a period written below the running count wraps on the next edge.
  assign terminal = (cnt_q >= period_q);

  // A compare value beyond the period leaves its channel inert, even on the single edge
  // where a shrunk period lets the counter sit above it.
  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      set_hit[i] = (cnt_q == set_q[i]) && (set_q[i] <= period_q);
      clr_hit[i] = (cnt_q == clr_q[i]) && (clr_q[i] <= period_q);
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    level_d = level_q;
    if (en) begin
      wrap_d = terminal;
      cnt_d  = terminal ? '0 : cnt_q + WIDTH'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        if (set_hit[i]) begin
          level_d[i] = 1'b1;
        end else if (clr_hit[i]) begin
          level_d[i] = 1'b0;
        end
      end
    end
  end

  // Writes land at the edge; compares this cycle still see the old register values.
  always_comb begin
    period_d = period_q;
    for (int i = 0; i < CHANNELS; i++) begin
      set_d[i] = set_q[i];
      clr_d[i] = clr_q[i];
    end
    if (cfg.cfg_we) begin
      if (cfg.cfg_sel == SEL_PERIOD) begin
        period_d = cfg.cfg_data;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg.cfg_chan == CHAN_W'(i)) begin
          if (cfg.cfg_sel == SEL_SET) set_d[i] = cfg.cfg_data;
          if (cfg.cfg_sel == SEL_CLR) clr_d[i] = cfg.cfg_data;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q    <= '0;
      period_q <= PERIOD_DEFAULT;
      level_q  <= '0;
      wrap_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        set_q[i] <= SET_DEFAULT;
        clr_q[i] <= CLR_DEFAULT;
      end
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      level_q  <= level_d;
      wrap_q   <= wrap_d;
      for (int i = 0; i < CHANNELS; i++) begin
        set_q[i] <= set_d[i];
        clr_q[i] <= clr_d[i];
      end
    end
  end

`ifdef PULSE_SEQ_STROBE_EN
  logic [CHANNELS-1:0] strobe_q, strobe_d;

  always_comb begin
    strobe_d = '0;
    if (en) begin
      strobe_d = set_hit;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;
`else
  assign strobe = '0;
`endif

  assign led   = cnt_q[LED_BIT];
  assign level = level_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_pulse_seq.sv
// Self-checking bench for pulse_seq: a reference model pushes the expected outputs of every
// edge into exp_q, and scenario tasks pop and compare them plus scenario-specific timings.
module tb_pulse_seq;

  localparam int WIDTH   = 10;
  localparam int CH      = 4;
  localparam int CW      = 2;
  localparam int LED_BIT = 9;
  localparam int EXP_W   = 1 + CH + CH + 1;

`ifdef PULSE_SEQ_STROBE_EN
  localparam bit STROBE_ON = 1'b1;
`else
  localparam bit STROBE_ON = 1'b0;
`endif

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          en;
  logic          led;
  logic [CH-1:0] level;
  logic [CH-1:0] strobe;
  logic          wrap;

  pulse_seq_if #(.WIDTH(WIDTH), .CHAN_W(CW)) cfg_if ();

  pulse_seq #(
    .WIDTH          (WIDTH),
    .CHANNELS       (CH),
    .PERIOD_DEFAULT (10'd1023),
    .SET_DEFAULT    (10'd572),
    .CLR_DEFAULT    (10'd999),
    .LED_BIT        (LED_BIT)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .cfg     (cfg_if),
    .led     (led),
    .level   (level),
    .strobe  (strobe),
    .wrap    (wrap)
  );

  // Clock / reset block
  always #5 sys_clk = ~sys_clk;

  int passed = 0;
  int total  = 0;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_w;
  logic [EXP_W-1:0] obs_w;

  // Reference model: reads only the bench's own stimulus.
  logic [WIDTH-1:0] m_cnt, m_per;
  logic [WIDTH-1:0] m_set [CH];
  logic [WIDTH-1:0] m_clr [CH];
  logic [CH-1:0]    m_level;

  always @(posedge sys_clk) begin : ref_model
    logic [WIDTH-1:0] c_n, p_n;
    logic [WIDTH-1:0] s_n [CH];
    logic [WIDTH-1:0] k_n [CH];
    logic [CH-1:0]    l_n, st_n;
    logic             w_n, hs, hc;
    if (sys_rst) begin
      c_n = '0; p_n = 10'd1023; l_n = '0; st_n = '0; w_n = 1'b0;
      for (int i = 0; i < CH; i++) begin
        s_n[i] = 10'd572;
        k_n[i] = 10'd999;
      end
    end else begin
      c_n = m_cnt; p_n = m_per; s_n = m_set; k_n = m_clr; l_n = m_level;
      st_n = '0; w_n = 1'b0;
      if (en) begin
        for (int i = 0; i < CH; i++) begin
          hs = (m_cnt == m_set[i]) && (m_set[i] <= m_per);
          hc = (m_cnt == m_clr[i]) && (m_clr[i] <= m_per);
          if (hs) l_n[i] = 1'b1;
          else if (hc) l_n[i] = 1'b0;
          st_n[i] = hs && STROBE_ON;
        end
        w_n = (m_cnt >= m_per);
        c_n = w_n ? '0 : m_cnt + 10'd1;
      end
      if (cfg_if.cfg_we) begin
        case (cfg_if.cfg_sel)
          2'd0:    s_n[cfg_if.cfg_chan] = cfg_if.cfg_data;
          2'd1:    k_n[cfg_if.cfg_chan] = cfg_if.cfg_data;
          2'd2:    p_n = cfg_if.cfg_data;
          default: ;
        endcase
      end
    end
    m_cnt   <= c_n;
    m_per   <= p_n;
    m_set   <= s_n;
    m_clr   <= k_n;
    m_level <= l_n;
    exp_q.push_back({c_n[LED_BIT], l_n, st_n, w_n});
  end

  // Driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
    obs_w = {led, level, strobe, wrap};
    if (exp_q.size() > 0) exp_w = exp_q.pop_front();
    else exp_w = 'x;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [CW-1:0] chan,
                           input logic [WIDTH-1:0] data);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_sel  = sel;
    cfg_if.cfg_chan = chan;
    cfg_if.cfg_data = data;
    step();
    cfg_if.cfg_we   = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst = 1'b1;
    en      = 1'b0;
    cfg_if.cfg_we = 1'b0;
    step();
    sys_rst = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    sys_rst = 1'b1;
    en      = 1'b1;
    cfg_if.cfg_we = 1'b1;
    cfg_if.cfg_sel = 2'd2;
    cfg_if.cfg_data = 10'd3;
    repeat (3) step();
    cfg_if.cfg_we = 1'b0;
    sys_rst = 1'b0;
    en      = 1'b0;
    step();
    total++;
    if (obs_w !== exp_w) $display("FAIL reset_model got %b want %b", obs_w, exp_w);
    else passed++;
    total++;
    if ({led, level, strobe, wrap} !== {EXP_W{1'b0}})
      $display("FAIL reset_outputs got %b want all zero", {led, level, strobe, wrap});
    else passed++;
  endtask

  task automatic test_defaults();
    int rise_n = -1, fall_n = -1, wrap_n = -1, led_n = -1, wrap_cnt = 0, strobe_cnt = 0;
    logic prev0 = 1'b0;
    en = 1'b1;
    for (int n = 1; n <= 1700; n++) begin
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL defaults_model n=%0d got %b want %b", n, obs_w, exp_w);
      else passed++;
      if (level[0] && !prev0 && rise_n < 0) rise_n = n;
      if (!level[0] && prev0 && fall_n < 0) fall_n = n;
      if (wrap && wrap_n < 0) wrap_n = n;
      if (led && led_n < 0) led_n = n;
      wrap_cnt   += int'(wrap);
      strobe_cnt += $countones(strobe);
      prev0 = level[0];
    end
    total++;
    if (rise_n !== 573) $display("FAIL defaults_rise got %0d want 573", rise_n); else passed++;
    total++;
    if (fall_n !== 1000) $display("FAIL defaults_fall got %0d want 1000", fall_n); else passed++;
    total++;
    if (wrap_n !== 1024) $display("FAIL defaults_wrap got %0d want 1024", wrap_n); else passed++;
    total++;
    if (wrap_cnt !== 1) $display("FAIL defaults_wrap_cnt got %0d want 1", wrap_cnt); else passed++;
    total++;
    if (led_n !== 512) $display("FAIL defaults_led got %0d want 512", led_n); else passed++;
    total++;
    if (strobe_cnt !== (STROBE_ON ? 8 : 0))
      $display("FAIL defaults_strobe_cnt got %0d want %0d", strobe_cnt, STROBE_ON ? 8 : 0);
    else passed++;
    total++;
    if (level !== 4'hF) $display("FAIL defaults_level_end got %b want 1111", level); else passed++;
  endtask

  task automatic test_same_compare();
    int rise1 = -1, rise0 = -1, drops = 0, strobe1 = 0;
    apply_reset();
    cfg_write(2'd0, 2'd1, 10'd10);
    cfg_write(2'd1, 2'd1, 10'd10);
    en = 1'b1;
    for (int n = 1; n <= 2100; n++) begin
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL same_model n=%0d got %b want %b", n, obs_w, exp_w);
      else passed++;
      if (rise1 >= 0 && !level[1]) drops++;
      if (level[1] && rise1 < 0) rise1 = n;
      if (level[0] && rise0 < 0) rise0 = n;
      strobe1 += int'(strobe[1]);
    end
    total++;
    if (rise1 !== 11) $display("FAIL same_rise1 got %0d want 11", rise1); else passed++;
    total++;
    if (drops !== 0) $display("FAIL same_hold got %0d low cycles want 0", drops); else passed++;
    total++;
    if (strobe1 !== (STROBE_ON ? 3 : 0))
      $display("FAIL same_strobe1 got %0d want %0d", strobe1, STROBE_ON ? 3 : 0);
    else passed++;
    total++;
    if (rise0 !== 573) $display("FAIL same_rise0 got %0d want 573", rise0); else passed++;
  endtask

  task automatic test_period_shrink();
    int wrap_cnt = 0, bad_level = 0, strobe_cnt = 0;
    apply_reset();
    en = 1'b1;
    for (int n = 1; n <= 800; n++) begin
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL shrink_model n=%0d got %b want %b", n, obs_w, exp_w);
      else passed++;
    end
    cfg_write(2'd2, 2'd0, 10'd5);
    total++;
    if (wrap !== 1'b0) $display("FAIL shrink_write_edge got %b want 0", wrap); else passed++;
    step();
    total++;
    if (wrap !== 1'b1) $display("FAIL shrink_forced_wrap got %b want 1", wrap); else passed++;
    for (int k = 1; k <= 60; k++) begin
      if (k == 1) begin
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_sel = 2'd3; cfg_if.cfg_chan = 2'd0;
        cfg_if.cfg_data = 10'd2;
      end
      step();
      cfg_if.cfg_we = 1'b0;
      total++;
      if (obs_w !== exp_w) $display("FAIL shrink_model k=%0d got %b want %b", k, obs_w, exp_w);
      else passed++;
      wrap_cnt   += int'(wrap);
      strobe_cnt += $countones(strobe);
      if (level !== 4'hF) bad_level++;
    end
    total++;
    if (wrap_cnt !== 10) $display("FAIL shrink_wrap_cnt got %0d want 10", wrap_cnt); else passed++;
    total++;
    if (bad_level !== 0) $display("FAIL shrink_level_hold got %0d bad want 0", bad_level);
    else passed++;
    total++;
    if (strobe_cnt !== 0) $display("FAIL shrink_inert got %0d strobes want 0", strobe_cnt);
    else passed++;
  endtask

  task automatic test_enable_hold();
    int bad = 0;
    apply_reset();
    en = 1'b1;
    for (int n = 1; n <= 572; n++) begin
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL hold_model n=%0d got %b want %b", n, obs_w, exp_w);
      else passed++;
    end
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL hold_model k=%0d got %b want %b", k, obs_w, exp_w);
      else passed++;
      if (level !== 4'h0 || strobe !== 4'h0 || wrap !== 1'b0) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL hold_quiet got %0d bad cycles want 0", bad); else passed++;
    en = 1'b1;
    step();
    total++;
    if (level !== 4'hF) $display("FAIL hold_resume_level got %b want 1111", level); else passed++;
    total++;
    if (strobe !== (STROBE_ON ? 4'hF : 4'h0))
      $display("FAIL hold_resume_strobe got %b want %b", strobe, STROBE_ON ? 4'hF : 4'h0);
    else passed++;
    step();
    total++;
    if (strobe !== 4'h0) $display("FAIL hold_strobe_once got %b want 0000", strobe); else passed++;
  endtask

  task automatic test_reset_mid();
    int rise2 = -1, wrap_n = -1;
    apply_reset();
    cfg_write(2'd0, 2'd2, 10'd100);
    cfg_write(2'd2, 2'd0, 10'd800);
    en = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL mid_model n=%0d got %b want %b", n, obs_w, exp_w);
      else passed++;
    end
    total++;
    if (level !== 4'hF) $display("FAIL mid_level_pre got %b want 1111", level); else passed++;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    total++;
    if ({level, strobe, wrap} !== 9'd0)
      $display("FAIL mid_reset_outputs got %b want 0", {level, strobe, wrap});
    else passed++;
    for (int n = 1; n <= 1100; n++) begin
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL mid_model2 n=%0d got %b want %b", n, obs_w, exp_w);
      else passed++;
      if (level[2] && rise2 < 0) rise2 = n;
      if (wrap && wrap_n < 0) wrap_n = n;
    end
    total++;
    if (rise2 !== 573) $display("FAIL mid_set_default got %0d want 573", rise2); else passed++;
    total++;
    if (wrap_n !== 1024) $display("FAIL mid_period_default got %0d want 1024", wrap_n);
    else passed++;
  endtask

  task automatic test_random();
    apply_reset();
    cfg_write(2'd2, 2'd0, 10'd40);
    for (int n = 0; n < 3000; n++) begin
      sys_rst         = ($urandom_range(0, 999) == 0);
      en              = ($urandom_range(0, 9) != 0);
      cfg_if.cfg_we   = ($urandom_range(0, 7) == 0);
      cfg_if.cfg_sel  = 2'($urandom_range(0, 3));
      cfg_if.cfg_chan = 2'($urandom_range(0, 3));
      cfg_if.cfg_data = 10'($urandom_range(0, 80));
      step();
      total++;
      if (obs_w !== exp_w) $display("FAIL random_model n=%0d got %b want %b", n, obs_w, exp_w);
      else passed++;
    end
    sys_rst = 1'b0;
    cfg_if.cfg_we = 1'b0;
  endtask

  initial begin
    sys_rst         = 1'b1;
    en              = 1'b0;
    cfg_if.cfg_we   = 1'b0;
    cfg_if.cfg_chan = '0;
    cfg_if.cfg_sel  = '0;
    cfg_if.cfg_data = '0;
    test_reset();
    test_defaults();
    test_same_compare();
    test_period_shrink();
    test_enable_hold();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
